rgmii_tx_ddr_gen: RTL and testbench

Parametrised RGMII transmit-side timing and data generator for the 10/100/1000 MAC path. It produces the per-cycle DDR TX clock phase pair, the MAC transmit clock enable, and registered DDR nibble/control lanes for the output ODDR stage. It generalises the fixed 10M/100M dividers to arbitrary periods, including odd periods via half-cycle phase granularity. It adds a synchronised speed input with glitch-free speed switching at period boundaries.

---
 rtl/rgmii_tx_ddr_gen.sv | 96 +++++++++
 tb/tb_rgmii_tx_ddr_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rgmii_tx_ddr_gen.sv
// RGMII TX timing/data generator: DDR clock phase pair, MAC clock enable and ODDR lanes.
// Latency 1 cycle for all outputs; speed changes apply only at TX clock period boundaries.
module rgmii_tx_ddr_gen #(
    parameter int DIV_10M     = 50,
    parameter int DIV_100M    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       gtx_clk,
    input  logic       gtx_rst,
    input  logic [1:0] speed,
    input  logic [7:0] mac_gmii_txd,
    input  logic       mac_gmii_tx_en,
    input  logic       mac_gmii_tx_er,
    output logic       mac_gmii_tx_clk_en,
    output logic [1:0] tx_clk_setting,
    output logic       tx_clk_rise,
    output logic [3:0] txd_1,
    output logic [3:0] txd_2,
    output logic       ctl_1,
    output logic       ctl_2,
    output logic [1:0] speed_active
);

    localparam int DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
    localparam int CW      = $clog2(DIV_MAX);

    // One extra bit so the period itself and 2c+1 both fit.
    typedef logic [CW:0] per_t;

    logic [1:0]    sync_q [SYNC_STAGES];
    logic [1:0]    speed_s;
    logic [CW-1:0] c;
    per_t          period;
    logic          last;
    logic          clk_1;
    logic          clk_2;
    logic          fall;
    logic          gig;

    always_ff @(posedge gtx_clk or posedge gtx_rst) begin
        if (gtx_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b10;
        end else begin
            sync_q[0] <= speed;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign speed_s = (sync_q[SYNC_STAGES-1] == 2'b11) ? 2'b10 : sync_q[SYNC_STAGES-1];

    always_comb begin
        period = per_t'(1);
        case (speed_active)
            2'b00:   period = per_t'(DIV_10M);
            2'b01:   period = per_t'(DIV_100M);
            default: period = per_t'(1);
        endcase
    end

    // Half-cycle phase: first half high while 2c < P, second half while 2c+1 < P.
    assign last  = ({1'b0, c} == period - per_t'(1));
    assign clk_1 = ({c, 1'b0} < period);
    assign clk_2 = ({c, 1'b1} < period);
    assign fall  = ({1'b0, c} == (period >> 1));
    assign gig   = (speed_active == 2'b10);

    always_ff @(posedge gtx_clk or posedge gtx_rst) begin
        if (gtx_rst) begin
            c                  <= '0;
            speed_active       <= 2'b10;
            tx_clk_setting     <= 2'b00;
            tx_clk_rise        <= 1'b0;
            mac_gmii_tx_clk_en <= 1'b0;
            txd_1              <= 4'h0;
            txd_2              <= 4'h0;
            ctl_1              <= 1'b0;
            ctl_2              <= 1'b0;
        end else begin
            if (last) begin
                c            <= '0;
                speed_active <= speed_s;
            end else begin
                c <= c + CW'(1);
            end
            tx_clk_setting     <= {clk_2, clk_1};
            tx_clk_rise        <= (c == '0);
            mac_gmii_tx_clk_en <= fall;
            txd_1              <= mac_gmii_txd[3:0];
            txd_2              <= gig ? mac_gmii_txd[7:4] : mac_gmii_txd[3:0];
            // Error is signalled on the low clock half, enable on the high half.
            ctl_1              <= clk_1 ? mac_gmii_tx_en : (mac_gmii_tx_en ^ mac_gmii_tx_er);
            ctl_2              <= clk_2 ? mac_gmii_tx_en : (mac_gmii_tx_en ^ mac_gmii_tx_er);
        end
    end

endmodule

// File: tb/tb_rgmii_tx_ddr_gen.sv
// Bench for rgmii_tx_ddr_gen: per-cycle scoreboard plus explicit phase/period measurements.
module tb_rgmii_tx_ddr_gen;

    localparam int D10  = 50;
    localparam int D100 = 5;
    localparam int SYNC = 2;

    logic       gtx_clk = 1'b0;
    logic       gtx_rst = 1'b1;
    logic [1:0] speed   = 2'b10;
    logic [7:0] txd     = 8'h00;
    logic       tx_en   = 1'b0;
    logic       tx_er   = 1'b0;
    logic       clk_en;
    logic [1:0] setting;
    logic       rise;
    logic [3:0] txd_1;
    logic [3:0] txd_2;
    logic       ctl_1;
    logic       ctl_2;
    logic [1:0] speed_active;

    rgmii_tx_ddr_gen #(.DIV_10M(D10), .DIV_100M(D100), .SYNC_STAGES(SYNC)) dut (
        .gtx_clk           (gtx_clk),
        .gtx_rst           (gtx_rst),
        .speed             (speed),
        .mac_gmii_txd      (txd),
        .mac_gmii_tx_en    (tx_en),
        .mac_gmii_tx_er    (tx_er),
        .mac_gmii_tx_clk_en(clk_en),
        .tx_clk_setting    (setting),
        .tx_clk_rise       (rise),
        .txd_1             (txd_1),
        .txd_2             (txd_2),
        .ctl_1             (ctl_1),
        .ctl_2             (ctl_2),
        .speed_active      (speed_active)
    );

    initial forever #4 gtx_clk = ~gtx_clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];
    int          m_c;
    logic [1:0]  m_spd;
    logic [1:0]  m_sync [SYNC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int per(input logic [1:0] s);
        return (s == 2'b00) ? D10 : (s == 2'b01) ? D100 : 1;
    endfunction

    task automatic reset_model();
        m_c   = 0;
        m_spd = 2'b10;
        for (int i = 0; i < SYNC; i++) m_sync[i] = 2'b10;
        exp_q.delete();
    endtask

    // Push expectation for the coming edge from current inputs, then compare after the edge.
    task automatic step();
        int p;
        logic [1:0] ss, nspd;
        logic h1, h2, e1, e2;
        logic [15:0] got;
        p    = per(m_spd);
        ss   = (m_sync[SYNC-1] == 2'b11) ? 2'b10 : m_sync[SYNC-1];
        nspd = (m_c == p - 1) ? ss : m_spd;
        h1   = (2 * m_c < p);
        h2   = (2 * m_c + 1 < p);
        e1   = h1 ? tx_en : (tx_en ^ tx_er);
        e2   = h2 ? tx_en : (tx_en ^ tx_er);
        exp_q.push_back({nspd, h2, h1, m_c == 0, m_c == p / 2, txd[3:0],
                         (m_spd == 2'b10) ? txd[7:4] : txd[3:0], e1, e2});
        m_c   = (m_c == p - 1) ? 0 : m_c + 1;
        m_spd = nspd;
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = speed;
        @(posedge gtx_clk);
        #1;
        got = {speed_active, setting, rise, clk_en, txd_1, txd_2, ctl_1, ctl_2};
        check("sb", got, exp_q.pop_front());
    endtask

    task automatic check_reset_vals();
        check("rst_set", setting, 2'b00);
        check("rst_rise", rise, 1'b0);
        check("rst_clk_en", clk_en, 1'b0);
        check("rst_txd", {txd_1, txd_2}, 8'h00);
        check("rst_ctl", {ctl_1, ctl_2}, 2'b00);
        check("rst_spd", speed_active, 2'b10);
    endtask

    task automatic wait_rise(input string tag);
        int n = 0;
        while (!rise && n < 200) begin
            step();
            n++;
        end
        if (!rise) check(tag, 0, 1);
    endtask

    logic [1:0] pat_set [5];
    logic       pat_en  [5];

    initial begin
        int n, len, hi, ens;
        pat_set = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
        pat_en  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        reset_model();
        #20;
        check_reset_vals();
        @(posedge gtx_clk);
        #1 gtx_rst = 1'b0;

        // 1000M steady
        txd = 8'hA5; tx_en = 1'b1; tx_er = 1'b0; speed = 2'b10;
        repeat (10) step();
        check("g_set", setting, 2'b01);
        check("g_lanes", {txd_2, txd_1}, 8'hA5);
        check("g_ctl", {ctl_1, ctl_2, clk_en, rise}, 4'b1111);

        // 100M pattern with en=1, er=1
        speed = 2'b01; txd = 8'h3C; tx_er = 1'b1;
        n = 0;
        while (speed_active != 2'b01 && n < 50) begin step(); n++; end
        check("m_switch", speed_active, 2'b01);
        repeat (2) step();
        wait_rise("m_rise_to");
        for (int i = 0; i < 10; i++) begin
            check("m_set", setting, pat_set[i % 5]);
            check("m_clk_en", clk_en, pat_en[i % 5]);
            if (i % 5 == 2) check("m_ctl_01", {ctl_1, ctl_2}, 2'b10);
            step();
        end

        // 100M -> 10M requested at c=1
        n = 0;
        while (m_c != 1 && n < 20) begin step(); n++; end
        speed = 2'b00;
        step();
        check("sw_hold", speed_active, 2'b01);
        wait_rise("sw_rise_to");
        check("sw_spd", speed_active, 2'b00);
        check("s_ctl_hi", {ctl_1, ctl_2}, 2'b11);
        len = 0; hi = 0; ens = 0;
        do begin
            if (setting == 2'b11) hi++;
            if (clk_en) ens++;
            if (len == 30) check("s_ctl_lo", {ctl_1, ctl_2}, 2'b00);
            step();
            len++;
        end while (!rise && len < 200);
        check("s_high_len", hi, 25);
        check("s_period", len, 50);
        check("s_clk_en_cnt", ens, 1);

        // er=0: TX_CTL constant in both halves
        tx_er = 1'b0;
        repeat (30) step();
        check("s_ctl_const", {ctl_1, ctl_2, setting}, 4'b1100);

        // Async reset in the 10M high phase
        wait_rise("r_rise_to");
        repeat (5) step();
        check("r_pre_hi", setting, 2'b11);
        #2 gtx_rst = 1'b1;
        #1;
        check_reset_vals();
        reset_model();
        repeat (2) @(posedge gtx_clk);
        #1 gtx_rst = 1'b0;
        step();
        check("r_spd_first", speed_active, 2'b10);
        n = 1;
        while (speed_active != 2'b00 && n < 20) begin step(); n++; end
        check("r_resume_cycles", n, SYNC + 1);
        repeat (60) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
